// File: rtl/rb_sequencer.sv
// Register-bank command sequencer: decodes one command at a time into
// register-bank write strobes and mux selects, then pulses done/err.
module rb_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_dst,
    input  logic [3:0] cmd_src1,
    input  logic [3:0] cmd_src2,
    input  logic [7:0] cmd_const,
    output logic [2:0] InMuxAdd,
    output logic       WE,
    output logic [3:0] RegAdd,
    output logic [3:0] OutMuxAdd,
    output logic [7:0] CUconst,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        ALU_A,
        ALU_B,
        ALU_WAIT,
        ALU_WB,
        FIN
    } state_t;

    localparam logic [2:0] OP_LDA = 3'd0;
    localparam logic [2:0] OP_LDB = 3'd1;
    localparam logic [2:0] OP_LDC = 3'd2;
    localparam logic [2:0] OP_MOV = 3'd3;
    localparam logic [2:0] OP_ALU = 3'd4;
    localparam logic [2:0] OP_OUT = 3'd5;

    localparam logic [2:0] IN_A     = 3'd0;
    localparam logic [2:0] IN_B     = 3'd1;
    localparam logic [2:0] IN_CONST = 3'd2;
    localparam logic [2:0] IN_ALU   = 3'd3;
    localparam logic [2:0] IN_REG   = 3'd4;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [3:0] dst_q, dst_d;
    logic [3:0] src1_q, src1_d;
    logic [3:0] src2_q, src2_d;
    logic [7:0] const_q, const_d;
    logic       err_flag_q, err_flag_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            dst_q      <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            const_q    <= '0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dst_q      <= dst_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            const_q    <= const_d;
            err_flag_q <= err_flag_d;
        end
    end

    // Next-state and command latching; fields only load in IDLE.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dst_d      = dst_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        const_d    = const_q;
        err_flag_d = err_flag_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    dst_d   = cmd_dst;
                    src1_d  = cmd_src1;
                    src2_d  = cmd_src2;
                    const_d = cmd_const;
                    state_d = (cmd_op == OP_ALU) ? ALU_A : EXEC;
                end
            end
            EXEC: begin
                if (op_q > OP_OUT) begin
                    err_flag_d = 1'b1;
                end
                state_d = FIN;
            end
            ALU_A:    state_d = ALU_B;
            ALU_B:    state_d = ALU_WAIT;
            ALU_WAIT: state_d = ALU_WB;
            ALU_WB:   state_d = FIN;
            FIN: begin
                err_flag_d = 1'b0;
                state_d    = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held so an aborted command
    // never issues a write in the reset cycle itself.
    always_comb begin
        cmd_ready = 1'b0;
        WE        = 1'b0;
        InMuxAdd  = '0;
        RegAdd    = '0;
        OutMuxAdd = '0;
        done      = 1'b0;
        err       = 1'b0;
        CUconst   = const_q;
        if (!reset) begin
            case (state_q)
                IDLE: cmd_ready = 1'b1;
                EXEC: begin
                    case (op_q)
                        OP_LDA: begin
                            WE       = 1'b1;
                            InMuxAdd = IN_A;
                            RegAdd   = dst_q;
                        end
                        OP_LDB: begin
                            WE       = 1'b1;
                            InMuxAdd = IN_B;
                            RegAdd   = dst_q;
                        end
                        OP_LDC: begin
                            WE       = 1'b1;
                            InMuxAdd = IN_CONST;
                            RegAdd   = dst_q;
                        end
                        OP_MOV: begin
                            WE        = 1'b1;
                            InMuxAdd  = IN_REG;
                            OutMuxAdd = src1_q;
                            RegAdd    = dst_q;
                        end
                        OP_OUT: begin
                            WE        = 1'b1;
                            InMuxAdd  = IN_REG;
                            OutMuxAdd = src1_q;
                            RegAdd    = 4'd0;
                        end
                        default: ;
                    endcase
                end
                ALU_A: begin
                    WE        = 1'b1;
                    InMuxAdd  = IN_REG;
                    OutMuxAdd = src1_q;
                    RegAdd    = 4'd1;
                end
                ALU_B: begin
                    WE        = 1'b1;
                    InMuxAdd  = IN_REG;
                    OutMuxAdd = src2_q;
                    RegAdd    = 4'd2;
                end
                ALU_WB: begin
                    WE       = 1'b1;
                    InMuxAdd = IN_ALU;
                    RegAdd   = dst_q;
                end
                FIN: begin
                    done = 1'b1;
                    err  = err_flag_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rb_sequencer.sv
// Self-checking bench for rb_sequencer: per-cycle comparison against a
// queue-of-expected-cycles model, plus directed literal scenarios.
module tb_rb_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [3:0] cmd_dst = '0;
    logic [3:0] cmd_src1 = '0;
    logic [3:0] cmd_src2 = '0;
    logic [7:0] cmd_const = '0;
    logic [2:0] InMuxAdd;
    logic       WE;
    logic [3:0] RegAdd;
    logic [3:0] OutMuxAdd;
    logic [7:0] CUconst;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    rb_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src1(cmd_src1),
        .cmd_src2(cmd_src2), .cmd_const(cmd_const),
        .InMuxAdd(InMuxAdd), .WE(WE), .RegAdd(RegAdd),
        .OutMuxAdd(OutMuxAdd), .CUconst(CUconst),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // One entry per cycle a command occupies after acceptance.
    typedef struct packed {
        logic       we;
        logic [2:0] inm;
        logic [3:0] ra;
        logic [3:0] om;
        logic       dn;
        logic       er;
    } rec_t;

    rec_t       q[$];
    logic [7:0] m_const = '0;

    function automatic rec_t mk(logic we, logic [2:0] inm, logic [3:0] ra,
                                logic [3:0] om, logic dn, logic er);
        rec_t r;
        r.we = we; r.inm = inm; r.ra = ra; r.om = om; r.dn = dn; r.er = er;
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_const = '0;
        end else if (q.size() > 0) begin
            void'(q.pop_front());
        end else if (cmd_valid) begin
            m_const = cmd_const;
            case (cmd_op)
                3'd0: q.push_back(mk(1, 0, cmd_dst, 0, 0, 0));
                3'd1: q.push_back(mk(1, 1, cmd_dst, 0, 0, 0));
                3'd2: q.push_back(mk(1, 2, cmd_dst, 0, 0, 0));
                3'd3: q.push_back(mk(1, 4, cmd_dst, cmd_src1, 0, 0));
                3'd5: q.push_back(mk(1, 4, 0, cmd_src1, 0, 0));
                3'd4: begin
                    q.push_back(mk(1, 4, 1, cmd_src1, 0, 0));
                    q.push_back(mk(1, 4, 2, cmd_src2, 0, 0));
                    q.push_back(mk(0, 0, 0, 0, 0, 0));
                    q.push_back(mk(1, 3, cmd_dst, 0, 0, 0));
                end
                default: q.push_back(mk(0, 0, 0, 0, 0, 0));
            endcase
            q.push_back(mk(0, 0, 0, 0, 1, (cmd_op > 3'd5)));
        end
    end

    // Packed as {ready, WE, InMuxAdd, RegAdd, OutMuxAdd, CUconst, done, err}.
    always @(negedge clk) begin
        logic [22:0] exp_v, act_v;
        if (chk_en) begin
            if (reset)
                exp_v = {1'b0, 1'b0, 3'd0, 4'd0, 4'd0, m_const, 1'b0, 1'b0};
            else if (q.size() == 0)
                exp_v = {1'b1, 1'b0, 3'd0, 4'd0, 4'd0, m_const, 1'b0, 1'b0};
            else
                exp_v = {1'b0, q[0].we, q[0].inm, q[0].ra, q[0].om, m_const, q[0].dn, q[0].er};
            act_v = {cmd_ready, WE, InMuxAdd, RegAdd, OutMuxAdd, CUconst, done, err};
            chk("cycle_outputs", {9'd0, act_v}, {9'd0, exp_v});
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) return;
        end
        chk("wait_idle_timeout", cmd_ready, 1);
    endtask

    // Presents a command for one cycle; returns just after cycle N+1 begins.
    task automatic issue(input logic [2:0] op, input logic [3:0] dst,
                         input logic [3:0] s1, input logic [3:0] s2, input logic [7:0] c);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst;
        cmd_src1 = s1; cmd_src2 = s2; cmd_const = c;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_we", WE, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_cuconst", CUconst, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_we", WE, 0);

        // LDC dst=5 const=0x3C
        wait_idle();
        issue(3'd2, 4'd5, 4'd0, 4'd0, 8'h3C);
        @(negedge clk);
        chk("ldc_we", WE, 1); chk("ldc_inmux", InMuxAdd, 2);
        chk("ldc_regadd", RegAdd, 5); chk("ldc_const", CUconst, 8'h3C);
        @(negedge clk);
        chk("ldc_done", done, 1); chk("ldc_err", err, 0);

        // ALU src1=3 src2=4 dst=7
        wait_idle();
        issue(3'd4, 4'd7, 4'd3, 4'd4, 8'h00);
        @(negedge clk);
        chk("alu_a_we", WE, 1); chk("alu_a_reg", RegAdd, 1); chk("alu_a_out", OutMuxAdd, 3);
        @(negedge clk);
        chk("alu_b_we", WE, 1); chk("alu_b_reg", RegAdd, 2); chk("alu_b_out", OutMuxAdd, 4);
        @(negedge clk);
        chk("alu_wait_we", WE, 0);
        @(negedge clk);
        chk("alu_wb_we", WE, 1); chk("alu_wb_in", InMuxAdd, 3); chk("alu_wb_reg", RegAdd, 7);
        @(negedge clk);
        chk("alu_done", done, 1);

        // OUT src1=9
        wait_idle();
        issue(3'd5, 4'd6, 4'd9, 4'd0, 8'h11);
        @(negedge clk);
        chk("out_we", WE, 1); chk("out_in", InMuxAdd, 4);
        chk("out_out", OutMuxAdd, 9); chk("out_reg", RegAdd, 0);
        @(negedge clk);
        chk("out_done", done, 1);

        // Illegal opcode, then a legal one must not carry err
        wait_idle();
        issue(3'd6, 4'd3, 4'd0, 4'd0, 8'h22);
        @(negedge clk);
        chk("ill_we", WE, 0);
        @(negedge clk);
        chk("ill_done", done, 1); chk("ill_err", err, 1);
        wait_idle();
        issue(3'd0, 4'd8, 4'd0, 4'd0, 8'h00);
        @(negedge clk);
        chk("lda_after_ill_we", WE, 1);
        @(negedge clk);
        chk("lda_after_ill_done", done, 1); chk("lda_after_ill_err", err, 0);

        // Reset during ALU_B aborts the command
        wait_idle();
        issue(3'd4, 4'd2, 4'd1, 4'd1, 8'h00);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_we", WE, 0); chk("abort_ready", cmd_ready, 0);
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_no_we", WE, 0);
            chk("abort_ready_after", cmd_ready, 1);
        end

        // Two commands with cmd_valid held high
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_dst = 4'd3;
        @(posedge clk); #1;
        cmd_op = 3'd1; cmd_dst = 4'd4;
        @(negedge clk);
        chk("b2b_busy1_ready", cmd_ready, 0); chk("b2b_first_reg", RegAdd, 3);
        chk("b2b_first_in", InMuxAdd, 0);
        @(negedge clk);
        chk("b2b_busy2_ready", cmd_ready, 0); chk("b2b_first_done", done, 1);
        @(negedge clk);
        chk("b2b_idle_ready", cmd_ready, 1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second_we", WE, 1); chk("b2b_second_in", InMuxAdd, 1);
        chk("b2b_second_reg", RegAdd, 4);

        // Random traffic, including fields changing mid-command and resets
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            reset     = ($urandom_range(0, 49) == 0);
            cmd_valid = ($urandom_range(0, 9) < 7);
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_dst   = 4'($urandom_range(0, 15));
            cmd_src1  = 4'($urandom_range(0, 15));
            cmd_src2  = 4'($urandom_range(0, 15));
            cmd_const = 8'($urandom_range(0, 255));
        end
        @(posedge clk); #1;
        reset = 1'b0; cmd_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
